reg_exec_unit: RTL and testbench

- Execute/writeback stage directly downstream of the 4-entry x 9-bit register file.
- Accepts one instruction per valid/ready handshake and drives the register file read addresses.
- Captures the two operands, computes a 9-bit result, and writes it back through the register file write port.
- Multiply is iterative (shift-add); all other ops take one execute cycle.

---
 rtl/reg_exec_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_reg_exec_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_exec_unit.sv
// reg_exec_unit: execute/writeback stage feeding a 4-entry register file.
// Define REG_EXEC_MUL_EN to build the iterative shift-add multiplier for op 101.
module reg_exec_unit #(
    parameter int unsigned W          = 9,
    parameter int unsigned MUL_CYCLES = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [2:0]   instr_op,
    input  logic [1:0]   instr_rd,
    input  logic [1:0]   instr_rs,
    input  logic [1:0]   instr_rt,
    input  logic [W-1:0] instr_imm,
    output logic [1:0]   rd0_addr,
    output logic [1:0]   rd1_addr,
    input  logic [W-1:0] rd0_data,
    input  logic [W-1:0] rd1_data,
    output logic         wr_en,
    output logic [1:0]   wr_addr,
    output logic [W-1:0] wr_data,
    output logic         busy,
    output logic         done,
    output logic         flag_zero,
    output logic         flag_carry
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;
    typedef enum logic [2:0] {
        OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
        OP_XOR = 3'b100, OP_MUL = 3'b101, OP_NOP = 3'b110, OP_LDI = 3'b111
    } op_t;

    if (MUL_CYCLES != W) begin : g_bad_cfg
        $error("reg_exec_unit: MUL_CYCLES must equal W");
    end

    state_t       state_q, state_d;
    op_t          op_q, op_d;
    logic [1:0]   rd_q, rd_d;
    logic [W-1:0] imm_q, imm_d;
    logic [1:0]   rd0_addr_q, rd0_addr_d, rd1_addr_q, rd1_addr_d;
    logic [W-1:0] a_q, a_d, b_q, b_d;
    logic         instr_ready_q, instr_ready_d, busy_q, busy_d, done_q, done_d;
    logic         wr_en_q, wr_en_d;
    logic [1:0]   wr_addr_q, wr_addr_d;
    logic [W-1:0] wr_data_q, wr_data_d;
    logic         flag_zero_q, flag_zero_d, flag_carry_q, flag_carry_d;

    logic [W:0]   sum_w;
    logic [W-1:0] exec_res;
    logic         exec_carry, exec_write, exec_last;

`ifdef REG_EXEC_MUL_EN
    localparam int unsigned CNT_W = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    logic [2*W-1:0] mcand_q, mcand_d, prod_q, prod_d, prod_acc;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Result of the current EXEC cycle; for MUL it is the running product.
    always_comb begin
        sum_w      = {1'b0, a_q} + {1'b0, b_q};
        exec_res   = '0;
        exec_carry = 1'b0;
        exec_write = 1'b1;
        exec_last  = 1'b1;
`ifdef REG_EXEC_MUL_EN
        prod_acc   = prod_q + (b_q[0] ? mcand_q : '0);
`endif
        case (op_q)
            OP_ADD: begin
                exec_res   = sum_w[W-1:0];
                exec_carry = sum_w[W];
            end
            OP_SUB: begin
                exec_res   = a_q - b_q;
                exec_carry = (a_q < b_q);
            end
            OP_AND: exec_res = a_q & b_q;
            OP_OR:  exec_res = a_q | b_q;
            OP_XOR: exec_res = a_q ^ b_q;
            OP_LDI: exec_res = imm_q;
`ifdef REG_EXEC_MUL_EN
            OP_MUL: begin
                exec_res   = prod_acc[W-1:0];
                exec_carry = |prod_acc[2*W-1:W];
                exec_last  = (cnt_q == CNT_LAST);
            end
`endif
            default: exec_write = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        rd_d          = rd_q;
        imm_d         = imm_q;
        rd0_addr_d    = rd0_addr_q;
        rd1_addr_d    = rd1_addr_q;
        a_d           = a_q;
        b_d           = b_q;
        instr_ready_d = instr_ready_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        flag_zero_d   = flag_zero_q;
        flag_carry_d  = flag_carry_q;
`ifdef REG_EXEC_MUL_EN
        mcand_d       = mcand_q;
        prod_d        = prod_q;
        cnt_d         = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    op_d          = op_t'(instr_op);
                    rd_d          = instr_rd;
                    imm_d         = instr_imm;
                    rd0_addr_d    = instr_rs;
                    rd1_addr_d    = instr_rt;
                    instr_ready_d = 1'b0;
                    busy_d        = 1'b1;
                    state_d       = S_READ;
                end
            end
            S_READ: begin
                a_d     = rd0_data;
                b_d     = rd1_data;
`ifdef REG_EXEC_MUL_EN
                mcand_d = {{W{1'b0}}, rd0_data};
                prod_d  = '0;
                cnt_d   = '0;
`endif
                state_d = S_EXEC;
            end
            S_EXEC: begin
`ifdef REG_EXEC_MUL_EN
                prod_d  = prod_acc;
                mcand_d = mcand_q << 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
`endif
                // Outputs are registered, so WB values are loaded on the last EXEC edge.
                if (exec_last) begin
                    done_d  = 1'b1;
                    state_d = S_WB;
                    if (exec_write) begin
                        wr_en_d      = 1'b1;
                        wr_addr_d    = rd_q;
                        wr_data_d    = exec_res;
                        flag_zero_d  = (exec_res == '0);
                        flag_carry_d = exec_carry;
                    end
                end
            end
            S_WB: begin
                instr_ready_d = 1'b1;
                busy_d        = 1'b0;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            op_q          <= OP_NOP;
            rd_q          <= '0;
            imm_q         <= '0;
            rd0_addr_q    <= '0;
            rd1_addr_q    <= '0;
            a_q           <= '0;
            b_q           <= '0;
            instr_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            flag_zero_q   <= 1'b0;
            flag_carry_q  <= 1'b0;
`ifdef REG_EXEC_MUL_EN
            mcand_q       <= '0;
            prod_q        <= '0;
            cnt_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            rd_q          <= rd_d;
            imm_q         <= imm_d;
            rd0_addr_q    <= rd0_addr_d;
            rd1_addr_q    <= rd1_addr_d;
            a_q           <= a_d;
            b_q           <= b_d;
            instr_ready_q <= instr_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            flag_zero_q   <= flag_zero_d;
            flag_carry_q  <= flag_carry_d;
`ifdef REG_EXEC_MUL_EN
            mcand_q       <= mcand_d;
            prod_q        <= prod_d;
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign instr_ready = instr_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign rd0_addr    = rd0_addr_q;
    assign rd1_addr    = rd1_addr_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign flag_zero   = flag_zero_q;
    assign flag_carry  = flag_carry_q;

endmodule

// File: tb/tb_reg_exec_unit.sv
// Bench for reg_exec_unit: register-file model, arithmetic reference model and
// a done-driven scoreboard. Honors REG_EXEC_MUL_EN the same way as the design.
module tb_reg_exec_unit;

    localparam int unsigned W = 9;
`ifdef REG_EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         instr_valid = 1'b0;
    logic         instr_ready;
    logic [2:0]   instr_op = '0;
    logic [1:0]   instr_rd = '0, instr_rs = '0, instr_rt = '0;
    logic [W-1:0] instr_imm = '0;
    logic [1:0]   rd0_addr, rd1_addr, wr_addr;
    logic [W-1:0] rd0_data, rd1_data, wr_data;
    logic         wr_en, busy, done, flag_zero, flag_carry;

    always #5 clk = ~clk;

    reg_exec_unit #(.W(W), .MUL_CYCLES(9)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs),
        .instr_rt(instr_rt), .instr_imm(instr_imm),
        .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
        .rd0_data(rd0_data), .rd1_data(rd1_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .flag_zero(flag_zero), .flag_carry(flag_carry)
    );

    // Register file: combinational read, write sampled on the negedge.
    logic [W-1:0] rf [4];
    logic         rf_clear = 1'b1;
    always @(negedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 4; i++) rf[i] <= '0;
        end else if (wr_en) begin
            rf[wr_addr] <= wr_data;
        end
    end
    assign rd0_data = rf[rd0_addr];
    assign rd1_data = rf[rd1_addr];

    int cyc = 0;
    int acc_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst && instr_valid && instr_ready) acc_cnt++;
    end

    typedef struct {
        int         cyc;
        bit         wr;
        logic [1:0] rd;
        logic [8:0] data;
        bit         z;
        bit         c;
        logic [1:0] rs;
        logic [1:0] rt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every done pulse retires one scoreboard entry.
    int ready_chk_cyc = -1;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("wr_en", {31'd0, wr_en}, {31'd0, e.wr});
                    if (e.wr) begin
                        chk("wr_addr", {30'd0, wr_addr}, {30'd0, e.rd});
                        chk("wr_data", {23'd0, wr_data}, {23'd0, e.data});
                    end
                    chk("flag_zero", {31'd0, flag_zero}, {31'd0, e.z});
                    chk("flag_carry", {31'd0, flag_carry}, {31'd0, e.c});
                    chk("rd0_addr", {30'd0, rd0_addr}, {30'd0, e.rs});
                    chk("rd1_addr", {30'd0, rd1_addr}, {30'd0, e.rt});
                    chk("busy_in_wb", {31'd0, busy}, 32'd1);
                    chk("ready_in_wb", {31'd0, instr_ready}, 32'd0);
                    ready_chk_cyc = cyc + 1;
                end
            end else begin
                chk("wr_en_outside_wb", {31'd0, wr_en}, 32'd0);
                if (cyc == ready_chk_cyc) begin
                    chk("ready_after_wb", {31'd0, instr_ready}, 32'd1);
                    chk("busy_after_wb", {31'd0, busy}, 32'd0);
                end
            end
        end
    end

    // Reference model: architectural register contents and flags.
    logic [8:0] m_reg [4];
    bit         m_z = 1'b0, m_c = 1'b0;

    task automatic model_exec(input logic [2:0] op, input logic [1:0] rd, rs, rt,
                              input logic [8:0] imm, input int t, output exp_t e);
        int unsigned a, b, full, res;
        bit wr, c;
        a = m_reg[rs];
        b = m_reg[rt];
        wr = 1'b1;
        c = 1'b0;
        res = 0;
        case (op)
            3'd0: begin full = a + b; res = full % 512; c = (full >= 512); end
            3'd1: begin res = (a + 512 - b) % 512; c = (a < b); end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: begin
                if (MUL_EN) begin full = a * b; res = full % 512; c = (full >= 512); end
                else wr = 1'b0;
            end
            3'd6: wr = 1'b0;
            default: res = imm;
        endcase
        if (wr) begin
            m_reg[rd] = res[8:0];
            m_z = (res == 0);
            m_c = c;
        end
        e.cyc  = t + ((op == 3'd5 && MUL_EN) ? 11 : 3);
        e.wr   = wr;
        e.rd   = rd;
        e.data = res[8:0];
        e.z    = m_z;
        e.c    = m_c;
        e.rs   = rs;
        e.rt   = rt;
    endtask

    // Called on a negedge; returns on the negedge after the accepting posedge.
    task automatic issue(input logic [2:0] op, input logic [1:0] rd, rs, rt,
                         input logic [8:0] imm, input bit hold, input bit push);
        exp_t e;
        int waited;
        instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt; instr_imm = imm;
        instr_valid = 1'b1;
        waited = 0;
        while (!instr_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!instr_ready) begin
            chk("accept_timeout", 32'd1, 32'd0);
            instr_valid = 1'b0;
            return;
        end
        model_exec(op, rd, rs, rt, imm, cyc, e);
        if (push) exp_q.push_back(e);
        @(negedge clk);
        if (!hold) instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int waited = 0;
        while ((!instr_ready || exp_q.size() != 0) && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 60) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int a0;
        for (int i = 0; i < 4; i++) m_reg[i] = '0;
        repeat (3) @(negedge clk);
        rf_clear = 1'b0;
        chk("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_flags", {30'd0, flag_zero, flag_carry}, 32'd0);
        chk("rst_wr_addr_data", {21'd0, wr_addr, wr_data}, 32'd0);
        chk("rst_rd_addrs", {28'd0, rd0_addr, rd1_addr}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Basic ADD
        issue(3'd7, 2'd1, 2'd0, 2'd0, 9'd13, 1'b0, 1'b1);
        issue(3'd7, 2'd2, 2'd0, 2'd0, 9'd117, 1'b0, 1'b1);
        issue(3'd0, 2'd3, 2'd1, 2'd2, 9'd0, 1'b0, 1'b1);
        wait_idle();
        chk("add_r3", {23'd0, rf[3]}, 32'd130);

        // Wrap and borrow
        issue(3'd7, 2'd1, 2'd0, 2'd0, 9'd500, 1'b0, 1'b1);
        issue(3'd7, 2'd2, 2'd0, 2'd0, 9'd20, 1'b0, 1'b1);
        issue(3'd0, 2'd3, 2'd1, 2'd2, 9'd0, 1'b0, 1'b1);
        wait_idle();
        chk("add_wrap_r3", {23'd0, rf[3]}, 32'd8);
        chk("add_wrap_carry", {31'd0, flag_carry}, 32'd1);
        issue(3'd1, 2'd0, 2'd2, 2'd1, 9'd0, 1'b0, 1'b1);
        wait_idle();
        chk("sub_borrow_r0", {23'd0, rf[0]}, 32'd32);
        issue(3'd1, 2'd0, 2'd1, 2'd2, 9'd0, 1'b0, 1'b1);
        wait_idle();
        chk("sub_r0", {23'd0, rf[0]}, 32'd480);
        chk("sub_carry", {31'd0, flag_carry}, 32'd0);

        // MUL (or NOP when the multiplier is not built)
        issue(3'd7, 2'd1, 2'd0, 2'd0, 9'd13, 1'b0, 1'b1);
        issue(3'd7, 2'd2, 2'd0, 2'd0, 9'd117, 1'b0, 1'b1);
        issue(3'd5, 2'd3, 2'd1, 2'd2, 9'd0, 1'b0, 1'b1);
        wait_idle();
`ifdef REG_EXEC_MUL_EN
        chk("mul_r3", {23'd0, rf[3]}, 32'd497);
`else
        chk("mul_as_nop_r3", {23'd0, rf[3]}, 32'd8);
`endif

        // Zero flag and NOP
        issue(3'd4, 2'd1, 2'd1, 2'd1, 9'd0, 1'b0, 1'b1);
        issue(3'd6, 2'd2, 2'd0, 2'd0, 9'd0, 1'b0, 1'b1);
        wait_idle();
        chk("nop_keeps_flags", {30'd0, flag_zero, flag_carry}, 32'd2);
        chk("xor_r1", {23'd0, rf[1]}, 32'd0);

        // Reset during the 5th EXEC cycle of a MUL
        issue(3'd7, 2'd1, 2'd0, 2'd0, 9'd13, 1'b0, 1'b1);
        issue(3'd5, 2'd3, 2'd1, 2'd2, 9'd0, 1'b0, !MUL_EN);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m_z = 1'b0;
        m_c = 1'b0;
        chk("midrst_ready", {31'd0, instr_ready}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("midrst_flags", {30'd0, flag_zero, flag_carry}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        wait_idle();
        chk("midrst_r3_unwritten", {23'd0, rf[3]}, MUL_EN ? 32'd497 : 32'd8);

        // valid held high across three dependent instructions
        a0 = acc_cnt;
        issue(3'd7, 2'd2, 2'd0, 2'd0, 9'd7, 1'b1, 1'b1);
        issue(3'd0, 2'd2, 2'd2, 2'd2, 9'd0, 1'b1, 1'b1);
        issue(3'd0, 2'd2, 2'd2, 2'd2, 9'd0, 1'b0, 1'b1);
        wait_idle();
        chk("handshake_accepts", acc_cnt - a0, 32'd3);
        chk("handshake_r2", {23'd0, rf[2]}, 32'd28);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            bit hold;
            hold = 1'($urandom_range(0, 1));
            issue(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 9'($urandom_range(0, 511)), hold, 1'b1);
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        instr_valid = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        for (int i = 0; i < 4; i++) chk("final_rf", {23'd0, rf[i]}, {23'd0, m_reg[i]});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
